// File: rtl/sample_burst_fifo_if.sv
// Sample buffer port bundle: write side, mode/control, registered output and status.
// Latency: none, wiring only.
// Backpressure: rd_ready from the sink stalls the buffer's output register.
interface sample_burst_fifo_if #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 6
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              mode;
  logic              clr_ovf;
  logic              rd_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [ADDR_W:0]   level;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;

  // Source/sink side: drives samples and ready, observes output and status.
  modport master (
    output wr_en, wr_data, mode, clr_ovf, rd_ready,
    input  out_valid, out_data, out_last, level, full, empty,
           almost_full, almost_empty, overflow
  );

  // Buffer side.
  modport slave (
    input  wr_en, wr_data, mode, clr_ovf, rd_ready,
    output out_valid, out_data, out_last, level, full, empty,
           almost_full, almost_empty, overflow
  );
endinterface

// File: rtl/sample_burst_fifo.sv
// Sample buffer with stream/burst read controller, level flags and sticky overflow.
// Latency: write to level 1 edge; write to out_valid 2 edges in stream mode.
// Backpressure: rd_ready low holds the output register; writes to a full buffer are dropped.
module sample_burst_fifo #(
  parameter int DATA_W    = 9,
  parameter int ADDR_W    = 6,
  parameter int AF_LEVEL  = 60,
  parameter int AE_LEVEL  = 4,
  parameter int BURST_LEN = 16
) (
  input  logic               sys_clk,
  input  logic               rst,
  sample_burst_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] BLEN_L  = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0] BLAST_L = (ADDR_W+1)'(BURST_LEN - 1);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  typedef enum logic {IDLE, BURST} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr, level_q;
  logic [ADDR_W:0]   bcnt, bcnt_nx, cnt;
  state_t            state, state_nx;
  logic              out_valid_q, out_last_q, overflow_q;
  logic [DATA_W-1:0] out_data_q;
  logic              full, empty, can_load, wr_acc, drop;
  logic              pop_ok, pop, last_nx, in_burst;

  // Flags are pure functions of the registered level.
  assign full     = (level_q == DEPTH_L);
  assign empty    = (level_q == '0);
  assign can_load = !out_valid_q || bus.rd_ready;
  assign wr_acc   = bus.wr_en && !full;
  assign drop     = bus.wr_en && full;

  // Read controller: decides whether a pop is allowed and tags the last word of a burst.
  always_comb begin
    state_nx = state;
    bcnt_nx  = bcnt;
    pop_ok   = 1'b0;
    last_nx  = 1'b0;
    in_burst = 1'b0;
    cnt      = bcnt;
    case (state)
      IDLE: begin
        cnt = '0;
        if (!bus.mode) begin
          pop_ok = 1'b1;
        end else if (level_q >= BLEN_L) begin
          // Burst starts now; this cycle's pop is word 0 of the burst.
          in_burst = 1'b1;
          pop_ok   = 1'b1;
          state_nx = BURST;
          bcnt_nx  = '0;
        end
      end
      BURST: begin
        in_burst = 1'b1;
        pop_ok   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    pop = can_load && !empty && pop_ok;
    if (in_burst && pop) begin
      if (cnt == BLAST_L) begin
        last_nx  = 1'b1;
        state_nx = IDLE;
        bcnt_nx  = '0;
      end else begin
        bcnt_nx = cnt + ONE;
      end
    end
  end

  // Controller state and burst word counter.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_nx;
      bcnt  <= bcnt_nx;
    end
  end

  // Sample storage; contents need no reset since pointers gate every read.
  always_ff @(posedge sys_clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
  end

  // Pointers and fill level; a write and a pop in the same cycle cancel on level.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (pop)    rd_ptr <= rd_ptr + ONE;
      if (wr_acc && !pop)      level_q <= level_q + ONE;
      else if (!wr_acc && pop) level_q <= level_q - ONE;
    end
  end

  // Output register: load on pop, drop valid when the word is taken and nothing replaces it.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mem[rd_ptr[ADDR_W-1:0]];
      out_last_q  <= last_nx;
    end else if (bus.rd_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)              overflow_q <= 1'b0;
    else if (drop)        overflow_q <= 1'b1;
    else if (bus.clr_ovf) overflow_q <= 1'b0;
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_last     = out_last_q;
  assign bus.level        = level_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level_q >= AF_L);
  assign bus.almost_empty = (level_q <= AE_L);
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_sample_burst_fifo.sv
// Self-checking bench for sample_burst_fifo: scoreboard queue of expected words.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: rd_ready driven from scenarios, including random toggling in burst mode.
module tb_sample_burst_fifo;
  localparam int DATA_W = 9;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_burst_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sample_burst_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(60), .AE_LEVEL(4), .BURST_LEN(16)
  ) dut (
    .sys_clk(clk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.mode = 1'b0;
    bus.clr_ovf = 1'b0; bus.rd_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.level !== 7'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", bus.level); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    n_cmp++; if (bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_ae got %b want 1", bus.almost_empty); end
    n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", bus.full); end
    n_cmp++; if (bus.almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_af got %b want 0", bus.almost_full); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 9'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b want 0", bus.out_last); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    int got;
    logic [DATA_W-1:0] e;
    got = 0;
    bus.mode = 1'b0; bus.rd_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid && bus.rd_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL stream_extra got %h want none", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin n_bad++; $display("FAIL stream_data got %h want %h", bus.out_data, e); end
        end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL stream_last got %b want 0", bus.out_last); end
        got++;
      end
      if (c < 5) begin
        bus.wr_en = 1'b1; bus.wr_data = DATA_W'(c + 1); exp_q.push_back(DATA_W'(c + 1));
      end else bus.wr_en = 1'b0;
      tick();
      // Edge c: valid after edges 1..5 (first write on edge 0).
      n_cmp++;
      if (bus.out_valid !== (c >= 1 && c <= 5)) begin
        n_bad++; $display("FAIL stream_valid_c%0d got %b want %b", c, bus.out_valid, (c >= 1 && c <= 5));
      end
      if (c == 0) begin
        n_cmp++; if (bus.level !== 7'd1) begin n_bad++; $display("FAIL stream_level1 got %0d want 1", bus.level); end
      end
    end
    n_cmp++; if (got != 5) begin n_bad++; $display("FAIL stream_count got %0d want 5", got); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL stream_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_fill_overflow();
    int lvl;
    logic [DATA_W-1:0] e;
    bus.mode = 1'b0; bus.rd_ready = 1'b0;
    for (int i = 1; i <= 66; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = DATA_W'(i + 'h100);
      if (i <= 65) exp_q.push_back(DATA_W'(i + 'h100));
      tick();
      // Word 1 moves to the output register; words 2..65 fill storage; word 66 is dropped.
      lvl = (i == 1) ? 1 : ((i - 1 > 64) ? 64 : i - 1);
      n_cmp++; if (bus.level !== 7'(lvl)) begin n_bad++; $display("FAIL fill_level_w%0d got %0d want %0d", i, bus.level, lvl); end
      n_cmp++; if (bus.full !== (lvl == 64)) begin n_bad++; $display("FAIL fill_full_w%0d got %b want %b", i, bus.full, (lvl == 64)); end
      n_cmp++; if (bus.almost_full !== (lvl >= 60)) begin n_bad++; $display("FAIL fill_af_w%0d got %b want %b", i, bus.almost_full, (lvl >= 60)); end
      n_cmp++; if (bus.almost_empty !== (lvl <= 4)) begin n_bad++; $display("FAIL fill_ae_w%0d got %b want %b", i, bus.almost_empty, (lvl <= 4)); end
      n_cmp++; if (bus.overflow !== (i == 66)) begin n_bad++; $display("FAIL fill_ovf_w%0d got %b want %b", i, bus.overflow, (i == 66)); end
    end
    n_cmp++; if (bus.out_data !== 9'h101) begin n_bad++; $display("FAIL fill_held_word got %h want 101", bus.out_data); end
    // Drop and clear together: set wins.
    bus.wr_data = 9'h1ff; bus.clr_ovf = 1'b1;
    tick();
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins got %b want 1", bus.overflow); end
    bus.wr_en = 1'b0;
    tick();
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b want 0", bus.overflow); end
    bus.clr_ovf = 1'b0;
    // Write while full with a pop in the same cycle: still dropped.
    bus.wr_en = 1'b1; bus.wr_data = 9'h1fe; bus.rd_ready = 1'b1;
    n_cmp++;
    e = exp_q.pop_front();
    if (!(bus.out_valid && bus.out_data === e)) begin n_bad++; $display("FAIL drop_pop_head got %h want %h", bus.out_data, e); end
    tick();
    bus.wr_en = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL drop_with_pop_ovf got %b want 1", bus.overflow); end
    n_cmp++; if (bus.level !== 7'd63) begin n_bad++; $display("FAIL drop_with_pop_level got %0d want 63", bus.level); end
    for (int c = 0; c < 200 && (exp_q.size() != 0 || bus.out_valid); c++) begin
      if (bus.out_valid && bus.rd_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL drain_extra got %h want none", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin n_bad++; $display("FAIL drain_data got %h want %h", bus.out_data, e); end
        end
      end
      bus.clr_ovf = (c == 0);
      tick();
    end
    bus.clr_ovf = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL drain_timeout got %0d left want 0", exp_q.size()); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL drain_ovf_clr got %b want 0", bus.overflow); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_burst();
    int got;
    logic [DATA_W-1:0] e;
    got = 0;
    bus.mode = 1'b1; bus.rd_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = DATA_W'(i + 'h80); exp_q.push_back(DATA_W'(i + 'h80));
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL burst_early_w%0d got %b want 0", i, bus.out_valid); end
    end
    bus.wr_en = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL burst_wait_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.level !== 7'd15) begin n_bad++; $display("FAIL burst_wait_level got %0d want 15", bus.level); end
    bus.wr_en = 1'b1; bus.wr_data = 9'h090; exp_q.push_back(9'h090);
    tick();
    bus.wr_en = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL burst_start_valid got %b want 0", bus.out_valid); end
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid && bus.rd_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL burst_extra got %h want none", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin n_bad++; $display("FAIL burst_data got %h want %h", bus.out_data, e); end
        end
        n_cmp++; if (bus.out_last !== (got == 15)) begin n_bad++; $display("FAIL burst_last_n%0d got %b want %b", got, bus.out_last, (got == 15)); end
        got++;
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== (c < 16)) begin n_bad++; $display("FAIL burst_valid_c%0d got %b want %b", c, bus.out_valid, (c < 16)); end
    end
    n_cmp++; if (got != 16) begin n_bad++; $display("FAIL burst_count got %0d want 16", got); end
    n_cmp++; if (bus.level !== 7'd0) begin n_bad++; $display("FAIL burst_level_end got %0d want 0", bus.level); end
  endtask

  task automatic test_burst_backpressure();
    int got;
    logic held_v, held_l;
    logic [DATA_W-1:0] held_d, e;
    got = 0;
    bus.mode = 1'b1; bus.rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = DATA_W'(i + 'h180); exp_q.push_back(DATA_W'(i + 'h180));
      tick();
    end
    bus.wr_en = 1'b0;
    for (int c = 0; c < 400 && got < 20; c++) begin
      bus.rd_ready = ($urandom_range(0, 1) == 1);
      // Mode drops to stream mid-burst; the burst must still complete with its last tag.
      if (c == 10) bus.mode = 1'b0;
      held_v = bus.out_valid && !bus.rd_ready;
      held_d = bus.out_data;
      held_l = bus.out_last;
      if (bus.out_valid && bus.rd_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_extra got %h want none", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin n_bad++; $display("FAIL bp_data_n%0d got %h want %h", got, bus.out_data, e); end
        end
        n_cmp++; if (bus.out_last !== (got == 15)) begin n_bad++; $display("FAIL bp_last_n%0d got %b want %b", got, bus.out_last, (got == 15)); end
        got++;
      end
      if (c < 4) begin
        bus.wr_en = 1'b1; bus.wr_data = DATA_W'(c + 'h1c0); exp_q.push_back(DATA_W'(c + 'h1c0));
      end else bus.wr_en = 1'b0;
      tick();
      if (held_v) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held_d || bus.out_last !== held_l) begin
          n_bad++; $display("FAIL bp_hold got v%b %h l%b want v1 %h l%b", bus.out_valid, bus.out_data, bus.out_last, held_d, held_l);
        end
      end
    end
    bus.wr_en = 1'b0; bus.rd_ready = 1'b1;
    n_cmp++; if (got != 20) begin n_bad++; $display("FAIL bp_count got %0d want 20", got); end
    tick();
    n_cmp++; if (bus.level !== 7'd0) begin n_bad++; $display("FAIL bp_level_end got %0d want 0", bus.level); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_end got %b want 0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] d, e;
    bus.mode = 1'b0; bus.rd_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      d = DATA_W'($urandom_range(0, 511));
      bus.wr_en = 1'b1; bus.wr_data = d; exp_q.push_back(d);
      tick();
    end
    n_cmp++; if (bus.level !== 7'd32) begin n_bad++; $display("FAIL wrap_prefill got %0d want 32", bus.level); end
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (bus.out_valid && bus.rd_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL wrap_extra got %h want none", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin n_bad++; $display("FAIL wrap_data_c%0d got %h want %h", c, bus.out_data, e); end
        end
      end
      d = DATA_W'($urandom_range(0, 511));
      bus.wr_en = 1'b1; bus.wr_data = d; exp_q.push_back(d);
      tick();
      n_cmp++; if (bus.level !== 7'd32) begin n_bad++; $display("FAIL wrap_level_c%0d got %0d want 32", c, bus.level); end
    end
    bus.wr_en = 1'b0;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || bus.out_valid); c++) begin
      if (bus.out_valid && bus.rd_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL wrap_drain_extra got %h want none", bus.out_data); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin n_bad++; $display("FAIL wrap_drain_data got %h want %h", bus.out_data, e); end
        end
      end
      tick();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_drain_timeout got %0d left want 0", exp_q.size()); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_reset_mid();
    bus.mode = 1'b1; bus.rd_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = DATA_W'(i + 'h40);
      tick();
    end
    bus.wr_en = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_busy got %b want 1", bus.out_valid); end
    // Assert reset between clock edges; outputs must clear without an edge.
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.level !== 7'd0) begin n_bad++; $display("FAIL rmid_level got %0d want 0", bus.level); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL rmid_empty got %b want 1", bus.empty); end
    n_cmp++; if (bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL rmid_ae got %b want 1", bus.almost_empty); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 9'd0) begin n_bad++; $display("FAIL rmid_data got %h want 0", bus.out_data); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL rmid_last got %b want 0", bus.out_last); end
    tick();
    rst = 1'b0; bus.mode = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_discard got %b want 0", bus.out_valid); end
    exp_q.delete();
    // The buffer works again in stream mode after reset.
    bus.wr_en = 1'b1; bus.wr_data = 9'h0aa;
    tick();
    bus.wr_en = 1'b0;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 9'h0aa) begin n_bad++; $display("FAIL rmid_restart got v%b %h want v1 0aa", bus.out_valid, bus.out_data); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_overflow();
    test_burst();
    test_burst_backpressure();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
